// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and helpers for the ioctl-to-SDRAM programming path.
// Holds the FIFO entry layout, lane masks, reset values and bank arithmetic.
package jtframe_dwnld_pkg;

    localparam int ENTRY_AW = 25;

    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;

    typedef struct packed {
        logic [1:0]          ba;
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
        logic [1:0]          mask;
    } prog_entry_t;

    localparam prog_entry_t ENTRY_RST = '{ba: 2'd0, addr: 25'd0, data: 8'd0, mask: 2'b11};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wr_state_t;

    function automatic logic [1:0] bank_sel(
        input logic [24:0] a,
        input logic [24:0] ba1,
        input logic [24:0] ba2,
        input logic [24:0] ba3
    );
        logic [1:0] ba;
        if (a >= ba3) begin
            ba = 2'd3;
        end else if (a >= ba2) begin
            ba = 2'd2;
        end else if (a >= ba1) begin
            ba = 2'd1;
        end else begin
            ba = 2'd0;
        end
        return ba;
    endfunction

    function automatic logic [24:0] bank_start(
        input logic [1:0]  ba,
        input logic [24:0] ba1,
        input logic [24:0] ba2,
        input logic [24:0] ba3
    );
        logic [24:0] start;
        case (ba)
            2'd1:    start = ba1;
            2'd2:    start = ba2;
            2'd3:    start = ba3;
            default: start = 25'd0;
        endcase
        return start;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO of programming entries with a synchronous clear.
// Push into a full FIFO and pop from an empty one are ignored.
module jtframe_prog_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  prog_entry_t din,
    input  logic        pop,
    output prog_entry_t dout,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 2 ** AW;

    prog_entry_t     mem_r [DEPTH];
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Extra pointer bit tells full from empty when the indices match
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        dout      = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update; clear drops everything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ENTRY_RST;
            end
        end else if (do_push_s && !clr) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/jtframe_ioctl_prog.sv
// Turns the MiST loader byte stream into SDRAM programming requests:
// header strip, four-bank mapping, byte buffering and busy/overflow reporting.
module jtframe_ioctl_prog
    import jtframe_dwnld_pkg::*;
#(
    parameter int          SDRAMW    = 23,
    parameter int          HEADER    = 0,
    parameter logic [24:0] BA1_START = 25'h10_0000,
    parameter logic [24:0] BA2_START = 25'h18_0000,
    parameter logic [24:0] BA3_START = 25'h1C_0000,
    parameter int          FIFOAW    = 2
)(
    input  logic              clk_rom,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              ovf
);

    localparam logic [24:0] HDR_OFS = 25'(HEADER);

    logic        keep_s;
    logic [24:0] rel_s;
    logic [1:0]  ba_s;
    logic [24:0] ofs_s;
    prog_entry_t entry_s;

    logic        stage_vld_r;
    prog_entry_t stage_r;
    logic        dl_prev_r;
    logic        clr_s;
    logic        push_s;

    prog_entry_t head_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;

    wr_state_t   state_r;
    wr_state_t   state_nxt_s;
    logic        we_r;
    logic        we_nxt_s;
    logic        load_s;
    prog_entry_t out_r;
    logic        busy_r;
    logic        busy_nxt_s;
    logic        ovf_r;

    // Header strip and bank/lane mapping of the incoming byte
    always_comb begin
        keep_s        = (ioctl_addr >= HDR_OFS);
        rel_s         = ioctl_addr - HDR_OFS;
        ba_s          = bank_sel(rel_s, BA1_START, BA2_START, BA3_START);
        ofs_s         = rel_s - bank_start(ba_s, BA1_START, BA2_START, BA3_START);
        entry_s.ba    = ba_s;
        entry_s.addr  = {1'b0, ofs_s[24:1]};
        entry_s.data  = ioctl_dout;
        entry_s.mask  = ofs_s[0] ? MASK_HI : MASK_LO;
    end

    // Input stage register and session-edge history
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_r <= 1'b0;
            stage_r     <= ENTRY_RST;
            dl_prev_r   <= 1'b0;
        end else begin
            stage_vld_r <= ioctl_wr & keep_s;
            stage_r     <= entry_s;
            dl_prev_r   <= downloading;
        end
    end

    // Fullness is judged before this cycle's pop, so a full FIFO rejects
    // the byte even when the FSM drains an entry on the same edge.
    always_comb begin
        clr_s  = downloading & ~dl_prev_r;
        push_s = stage_vld_r & ~fifo_full_s & ~clr_s;
    end

    jtframe_prog_fifo #(
        .AW    (FIFOAW)
    ) u_fifo (
        .clk   (clk_rom),
        .rst_n (rst_n),
        .clr   (clr_s),
        .push  (push_s),
        .din   (stage_r),
        .pop   (load_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Write FSM next state, request strobe and head load
    always_comb begin
        state_nxt_s = state_r;
        we_nxt_s    = we_r;
        load_s      = 1'b0;
        if (clr_s) begin
            state_nxt_s = ST_IDLE;
            we_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_nxt_s = ST_WAIT;
                        we_nxt_s    = 1'b1;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        we_nxt_s    = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (prog_rdy) begin
                        state_nxt_s = ST_IDLE;
                        we_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        we_nxt_s    = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    we_nxt_s    = 1'b0;
                end
            endcase
        end
        busy_nxt_s = downloading | ~fifo_empty_s | stage_vld_r | (state_r == ST_WAIT);
    end

    // FSM state and registered programming outputs
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            out_r   <= ENTRY_RST;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            we_r    <= we_nxt_s;
            busy_r  <= busy_nxt_s;
            if (load_s) begin
                out_r <= head_s;
            end
        end
    end

    // Sticky overflow flag, cleared only by a new session
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (clr_s) begin
            ovf_r <= 1'b0;
        end else if (stage_vld_r && fifo_full_s) begin
            ovf_r <= 1'b1;
        end
    end

    assign prog_addr  = SDRAMW'(out_r.addr);
    assign prog_data  = {out_r.data, out_r.data};
    assign prog_mask  = out_r.mask;
    assign prog_ba    = out_r.ba;
    assign prog_we    = we_r;
    assign dwnld_busy = busy_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_jtframe_ioctl_prog.sv
// Scoreboard bench for jtframe_ioctl_prog: stimulus pushes expected writes,
// an independent monitor pops and compares each SDRAM request.
module tb_jtframe_ioctl_prog;

    localparam int SDRAMW = 23;

    logic              clk_rom     = 1'b0;
    logic              rst_n       = 1'b0;
    logic              downloading = 1'b0;
    logic [24:0]       ioctl_addr  = 25'd0;
    logic [7:0]        ioctl_dout  = 8'd0;
    logic              ioctl_wr    = 1'b0;
    logic              prog_rdy    = 1'b0;
    logic [SDRAMW-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic [1:0]        prog_mask;
    logic [1:0]        prog_ba;
    logic              prog_we;
    logic              dwnld_busy;
    logic              ovf;

    int          n_vec     = 0;
    int          n_err     = 0;
    logic [42:0] exp_q[$];
    int          rdy_delay = 2;
    bit          rdy_en    = 1'b0;
    int          done_cnt  = 0;
    bit          gap_chk   = 1'b0;

    always #5 clk_rom = ~clk_rom;

    jtframe_ioctl_prog #(
        .SDRAMW    (SDRAMW),
        .HEADER    (2),
        .BA1_START (25'h8),
        .BA2_START (25'h20),
        .BA3_START (25'h40),
        .FIFOAW    (2)
    ) dut (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_ba     (prog_ba),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .ovf         (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},   prog_we,    1'b0);
        chk({tag, "_addr"}, prog_addr,  23'd0);
        chk({tag, "_data"}, prog_data,  16'd0);
        chk({tag, "_mask"}, prog_mask,  2'b11);
        chk({tag, "_ba"},   prog_ba,    2'd0);
        chk({tag, "_busy"}, dwnld_busy, 1'b0);
        chk({tag, "_ovf"},  ovf,        1'b0);
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, input bit kept,
                        input logic [1:0] eba, input logic [22:0] eaddr,
                        input logic [1:0] emask, input int idle);
        @(negedge clk_rom);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (kept) exp_q.push_back({eba, eaddr, d, d, emask});
        @(negedge clk_rom);
        ioctl_wr = 1'b0;
        repeat (idle) @(negedge clk_rom);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || prog_we) && t < 3000) begin
            @(negedge clk_rom);
            t++;
        end
        chk(name, (t >= 3000), 1'b0);
    endtask

    // Controller model: acknowledges a held request after rdy_delay cycles
    initial begin : responder
        int wait_cnt = 0;
        forever begin
            @(negedge clk_rom);
            prog_rdy = 1'b0;
            if (rdy_en && prog_we && rst_n) begin
                if (wait_cnt >= rdy_delay) begin
                    prog_rdy = 1'b1;
                    wait_cnt = 0;
                    done_cnt++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compare each new request, hold stability and the low gap
    initial begin : monitor
        logic        prev_we  = 1'b0;
        logic [42:0] cur      = 43'd0;
        logic [42:0] got;
        int          gap      = 0;
        bit          had_fall = 1'b0;
        forever begin
            @(negedge clk_rom);
            got = {prog_ba, prog_addr, prog_data, prog_mask};
            if (prog_we && !prev_we) begin
                if (exp_q.size() == 0) begin
                    chk("write_expected", exp_q.size(), 1);
                end else begin
                    chk("write", got, exp_q.pop_front());
                end
                if (gap_chk && had_fall) chk("we_gap", gap, 1);
                cur = got;
            end else if (prog_we && prev_we) begin
                chk("hold_stable", got, cur);
            end else if (!prog_we && prev_we) begin
                gap      = 1;
                had_fall = 1'b1;
            end else begin
                gap++;
            end
            prev_we = prog_we;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        int t;
        repeat (3) @(negedge clk_rom);
        chk_reset("reset");
        rst_n  = 1'b1;
        rdy_en = 1'b1;
        @(negedge clk_rom);
        downloading = 1'b1;
        @(negedge clk_rom);

        // header bytes dropped, then bank mapping around each boundary
        send(25'h0,    8'h11, 1'b0, 2'd0, 23'h0,   2'b10, 6);
        send(25'h1,    8'h22, 1'b0, 2'd0, 23'h0,   2'b10, 6);
        send(25'h2,    8'h33, 1'b1, 2'd0, 23'h0,   2'b10, 6);
        send(25'h3,    8'h44, 1'b1, 2'd0, 23'h0,   2'b01, 6);
        send(25'hB,    8'h55, 1'b1, 2'd1, 23'h0,   2'b01, 6);
        send(25'h9,    8'h66, 1'b1, 2'd0, 23'h3,   2'b01, 6);
        send(25'hA,    8'h77, 1'b1, 2'd1, 23'h0,   2'b10, 6);
        send(25'h27,   8'h88, 1'b1, 2'd2, 23'h2,   2'b01, 6);
        send(25'h1002, 8'h99, 1'b1, 2'd3, 23'h7E0, 2'b10, 6);
        send(25'h22,   8'hAA, 1'b1, 2'd2, 23'h0,   2'b10, 6);
        send(25'h21,   8'hBB, 1'b1, 2'd1, 23'hB,   2'b01, 6);
        wait_drain("drain_map");

        // overflow: 1 in WAIT + 4 queued, sixth byte dropped
        rdy_delay = 40;
        send(25'h100, 8'hD0, 1'b1, 2'd3, 23'h5F, 2'b10, 0);
        send(25'h101, 8'hD1, 1'b1, 2'd3, 23'h5F, 2'b01, 0);
        send(25'h102, 8'hD2, 1'b1, 2'd3, 23'h60, 2'b10, 0);
        send(25'h103, 8'hD3, 1'b1, 2'd3, 23'h60, 2'b01, 0);
        send(25'h104, 8'hD4, 1'b1, 2'd3, 23'h61, 2'b10, 0);
        send(25'h105, 8'hD5, 1'b0, 2'd3, 23'h61, 2'b01, 0);
        gap_chk = 1'b1;
        repeat (4) @(negedge clk_rom);
        chk("ovf_set", ovf, 1'b1);
        chk("busy_during_ovf", dwnld_busy, 1'b1);
        wait_drain("drain_ovf");
        gap_chk = 1'b0;
        chk("ovf_sticky", ovf, 1'b1);
        rdy_delay   = 2;
        downloading = 1'b0;
        repeat (2) @(negedge clk_rom);
        chk("ovf_sticky_idle", ovf, 1'b1);
        downloading = 1'b1;
        @(negedge clk_rom);
        chk("ovf_cleared", ovf, 1'b0);

        // busy persists after downloading falls until the last write completes
        rdy_delay = 5;
        base      = done_cnt;
        send(25'h4, 8'hE0, 1'b1, 2'd0, 23'h1, 2'b10, 0);
        send(25'h5, 8'hE1, 1'b1, 2'd0, 23'h1, 2'b01, 0);
        send(25'h6, 8'hE2, 1'b1, 2'd0, 23'h2, 2'b10, 0);
        downloading = 1'b0;
        gap_chk     = 1'b1;
        chk("busy_queued", dwnld_busy, 1'b1);
        t = 0;
        while (done_cnt < base + 3 && t < 500) begin
            @(posedge clk_rom);
            t++;
        end
        chk("busy_rdy_timeout", (t >= 500), 1'b0);
        @(negedge clk_rom);
        chk("busy_hold", dwnld_busy, 1'b1);
        @(negedge clk_rom);
        chk("busy_fall", dwnld_busy, 1'b0);
        gap_chk = 1'b0;

        // reset while a write is held in WAIT
        downloading = 1'b1;
        rdy_en      = 1'b0;
        @(negedge clk_rom);
        send(25'h1002, 8'hC3, 1'b1, 2'd3, 23'h7E0, 2'b10, 0);
        t = 0;
        while (!prog_we && t < 50) begin
            @(negedge clk_rom);
            t++;
        end
        chk("we_rise_timeout", (t >= 50), 1'b0);
        repeat (3) @(negedge clk_rom);
        chk("we_held", prog_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge clk_rom);
        rst_n     = 1'b1;
        rdy_en    = 1'b1;
        rdy_delay = 3;
        repeat (2) @(negedge clk_rom);
        send(25'h2A, 8'h5A, 1'b1, 2'd2, 23'h4,  2'b00 | 2'b10, 4);
        send(25'h43, 8'hA5, 1'b1, 2'd3, 23'h0,  2'b01, 4);
        wait_drain("drain_after_reset");
        chk("leftover_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
